// File: rtl/vga_display_scheduler.sv
// Frame-synchronous pixel source scheduler for the VGA timing driver.
// Selects one of NUM_SRC pixel sources and switches only on a frame tick
// (falling edge of fsync). A switch happens on request or when the auto dwell
// timer expires. Each switch can be followed by MUTE_FRAMES black frames.
// Optional feature macro: VGA_SCHED_BORDER_EN (forces a white one-pixel border
// while not muted).
module vga_display_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DW           = 30,
  parameter int unsigned SW           = 2,
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned MUTE_FRAMES  = 1,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned V_DISP       = 480
) (
  input  logic                  driver_clk,
  input  logic                  sys_rst_n,
  input  logic                  fsync,
  input  logic [9:0]            pixel_xpos,
  input  logic [9:0]            pixel_ypos,
  input  logic [NUM_SRC*DW-1:0] src_data,
  input  logic                  auto_en,
  input  logic                  req_valid,
  input  logic [SW-1:0]         req_src,
  output logic                  req_ready,
  output logic [DW-1:0]         data_from_display,
  output logic [SW-1:0]         cur_src,
  output logic                  switch_pulse
);

  localparam int unsigned DCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int unsigned MCW = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;
  localparam logic [DCW-1:0] DwellLast = DCW'(DWELL_FRAMES - 1);
  localparam logic [MCW-1:0] MuteLast  = MCW'(MUTE_FRAMES - 1);

  typedef enum logic [1:0] {StRun, StPend, StMute} state_e;

  state_e          state_q, state_d;
  logic            fsync_q;  // fsync delayed by one cycle; resets low so release never ticks
  logic            tick;
  logic [SW-1:0]   cur_src_q, cur_src_d;
  logic [SW-1:0]   pend_src_q, pend_src_d;
  logic [DCW-1:0]  dwell_q, dwell_d;
  logic [MCW-1:0]  mute_q, mute_d;
  logic            pulse_q, pulse_d;
  logic [DW-1:0]   data_q, data_d;
  logic            switch_en;
  logic [SW-1:0]   switch_src;
  logic [SW-1:0]   next_src;
  logic            req_take;
  logic            auto_expire;
  logic [DW-1:0]   src_pix;
  logic [DW-1:0]   pix_sel;

  assign tick        = fsync_q & ~fsync;
  assign req_ready   = (state_q == StRun);
  // Out-of-range or same-source requests are accepted but dropped.
  assign req_take    = req_valid & req_ready & (32'(req_src) < NUM_SRC) & (req_src != cur_src_q);
  assign auto_expire = auto_en & tick & (dwell_q == DwellLast);
  assign next_src    = (cur_src_q == SW'(NUM_SRC - 1)) ? '0 : cur_src_q + SW'(1);

  assign src_pix = src_data[cur_src_q*DW +: DW];

`ifdef VGA_SCHED_BORDER_EN
  logic on_border;
  assign on_border = (pixel_xpos == 10'(1)) | (pixel_xpos == 10'(H_DISP)) |
                     (pixel_ypos == 10'(1)) | (pixel_ypos == 10'(V_DISP));
  assign pix_sel   = on_border ? '1 : src_pix;
`else
  logic unused_pos;
  assign unused_pos = ^{pixel_xpos, pixel_ypos, 10'(H_DISP), 10'(V_DISP)};
  assign pix_sel    = src_pix;
`endif

  // Next-state: request/auto arbitration, frame-synchronous switching, mute countdown.
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    pend_src_d = pend_src_q;
    dwell_d    = dwell_q;
    mute_d     = mute_q;
    pulse_d    = 1'b0;
    switch_en  = 1'b0;
    switch_src = cur_src_q;
    unique case (state_q)
      StRun: begin
        if (req_take) begin
          pend_src_d = req_src;
          state_d    = StPend;
        end else if (auto_expire) begin
          switch_en  = 1'b1;
          switch_src = next_src;
        end else if (auto_en && tick) begin
          dwell_d = dwell_q + DCW'(1);
        end
      end
      StPend: begin
        if (tick) begin
          switch_en  = 1'b1;
          switch_src = pend_src_q;
        end
      end
      StMute: begin
        if (tick) begin
          if (mute_q == MuteLast) begin
            state_d = StRun;
            mute_d  = '0;
          end else begin
            mute_d = mute_q + MCW'(1);
          end
        end
      end
      default: state_d = StRun;
    endcase
    if (switch_en) begin
      cur_src_d = switch_src;
      pulse_d   = 1'b1;
      mute_d    = '0;
      state_d   = (MUTE_FRAMES > 0) ? StMute : StRun;
    end
    // Dwell only accumulates while running in auto mode.
    if (switch_en || !auto_en || (state_d != StRun)) begin
      dwell_d = '0;
    end
    data_d = (state_q == StMute) ? '0 : pix_sel;
  end

  // State and output registers.
  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StRun;
      fsync_q    <= 1'b0;
      cur_src_q  <= '0;
      pend_src_q <= '0;
      dwell_q    <= '0;
      mute_q     <= '0;
      pulse_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      fsync_q    <= fsync;
      cur_src_q  <= cur_src_d;
      pend_src_q <= pend_src_d;
      dwell_q    <= dwell_d;
      mute_q     <= mute_d;
      pulse_q    <= pulse_d;
      data_q     <= data_d;
    end
  end

  assign data_from_display = data_q;
  assign cur_src           = cur_src_q;
  assign switch_pulse      = pulse_q;

endmodule

// File: tb/tb_vga_display_scheduler.sv
// Self-checking bench for vga_display_scheduler: short synthetic frames, a
// frame-level reference model, directed scenarios followed by random traffic.
module tb_vga_display_scheduler;

  localparam int NS    = 4;
  localparam int DW    = 30;
  localparam int SW    = 3;
  localparam int DWELL = 3;
  localparam int MUTE  = 2;
  localparam int FL    = 10;  // cycles per synthetic frame, fsync low for the first two

  logic              driver_clk = 1'b0;
  logic              sys_rst_n  = 1'b1;
  logic              fsync      = 1'b1;
  logic [9:0]        pixel_xpos = '0;
  logic [9:0]        pixel_ypos = '0;
  logic [NS*DW-1:0]  src_data   = '0;
  logic              auto_en    = 1'b0;
  logic              req_valid  = 1'b0;
  logic [SW-1:0]     req_src    = '0;
  logic              req_ready;
  logic [DW-1:0]     data_from_display;
  logic [SW-1:0]     cur_src;
  logic              switch_pulse;

  vga_display_scheduler #(
    .NUM_SRC(NS), .DW(DW), .SW(SW), .DWELL_FRAMES(DWELL), .MUTE_FRAMES(MUTE),
    .H_DISP(640), .V_DISP(480)
  ) dut (
    .driver_clk(driver_clk), .sys_rst_n(sys_rst_n), .fsync(fsync),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .src_data(src_data),
    .auto_en(auto_en), .req_valid(req_valid), .req_src(req_src),
    .req_ready(req_ready), .data_from_display(data_from_display),
    .cur_src(cur_src), .switch_pulse(switch_pulse)
  );

  always #5 driver_clk = ~driver_clk;

  int vectors = 0;
  int miscompares = 0;
  int fpos = 0;
  bit stuck = 1'b0;
  bit rnd_pix = 1'b1;

  // Reference model: frame-level view of the scheduler.
  typedef enum int {MRun, MPend, MMute} mmode_e;
  mmode_e        m_mode;
  int            m_src, m_pend, m_dwell, m_mute;
  bit            m_prev_fs, m_pulse;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MRun; m_src = 0; m_pend = 0; m_dwell = 0; m_mute = 0;
    m_prev_fs = 1'b0; m_pulse = 1'b0; m_data = '0;
  endtask

  task automatic model_switch(input int n);
    m_src = n; m_pulse = 1'b1; m_dwell = 0; m_mute = 0;
    m_mode = (MUTE > 0) ? MMute : MRun;
  endtask

  function automatic logic [DW-1:0] src_of(input int i);
    return src_data[i*DW +: DW];
  endfunction

  task automatic model_clock();
    bit tick, border;
    logic [DW-1:0] nd;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    tick = m_prev_fs && !fsync;
    border = 1'b0;
`ifdef VGA_SCHED_BORDER_EN
    border = (pixel_xpos == 1) || (pixel_xpos == 640) || (pixel_ypos == 1) || (pixel_ypos == 480);
`endif
    if (m_mode == MMute) nd = '0;
    else if (border) nd = '1;
    else nd = src_of(m_src);
    m_pulse = 1'b0;
    case (m_mode)
      MRun: begin
        if (req_valid && int'(req_src) < NS && int'(req_src) != m_src) begin
          m_pend = int'(req_src); m_mode = MPend; m_dwell = 0;
        end else if (auto_en && tick) begin
          if (m_dwell == DWELL - 1) model_switch((m_src + 1) % NS);
          else m_dwell++;
        end else if (!auto_en) begin
          m_dwell = 0;
        end
      end
      MPend: if (tick) model_switch(m_pend);
      MMute: begin
        if (tick) begin
          if (m_mute == MUTE - 1) begin m_mode = MRun; m_mute = 0; end
          else m_mute++;
        end
      end
      default: ;
    endcase
    m_data = nd;
    m_prev_fs = fsync;
  endtask

  function automatic logic [9:0] pick_pos(input int last);
    case ($urandom_range(0, 4))
      0: return 10'd0;
      1: return 10'd1;
      2: return 10'd2;
      3: return 10'(last);
      default: return 10'($urandom_range(3, last - 1));
    endcase
  endfunction

  // One clock: drive inputs, advance model with the DUT, compare all outputs.
  task automatic step();
    if (rnd_pix) begin
      for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = DW'($urandom) | DW'(1);
      pixel_xpos = pick_pos(640);
      pixel_ypos = pick_pos(480);
    end
    fsync = stuck ? 1'b1 : (fpos < 2 ? 1'b0 : 1'b1);
    @(posedge driver_clk);
    model_clock();
    #1;
    check("data", data_from_display, m_data);
    check("cur_src", cur_src, m_src);
    check("req_ready", req_ready, m_mode == MRun);
    check("switch_pulse", switch_pulse, m_pulse);
    fpos = (fpos + 1) % FL;
  endtask

  task automatic request(input int s);
    req_valid = 1'b1;
    req_src = SW'(s);
    step();
    req_valid = 1'b0;
  endtask

  // Asynchronous reset mid-frame; release so the first post-reset cycle has fsync low.
  task automatic do_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_data", data_from_display, 0);
    check("rst_cur_src", cur_src, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_pulse", switch_pulse, 0);
    repeat (3) step();
    while (fpos != 0) step();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, last, n, saved;
    logic [DW-1:0] exp_pix;
    model_reset();
    #1;
    auto_en = 1'b1;
    do_reset();

    // Auto rotation 0->1->2->3->0; the skipped release tick shifts every switch.
    last = 0;
    pulses = 0;
    repeat (230) begin
      step();
      if (switch_pulse) begin
        last = (last + 1) % NS;
        check("auto_seq", cur_src, last);
        pulses++;
      end
    end
    check("auto_count_ge4", pulses >= 4, 1);

    // Same-source and out-of-range requests are swallowed.
    auto_en = 1'b0;
    n = 0;
    while (m_mode != MRun && n < 100) begin step(); n++; end
    check("settle_run", req_ready, 1);
    saved = m_src;
    request(saved);
    check("same_src_ready", req_ready, 1);
    request(5);
    check("oor_ready", req_ready, 1);
    pulses = 0;
    repeat (30) begin step(); if (switch_pulse) pulses++; end
    check("drop_no_pulse", pulses, 0);
    check("drop_cur_src", cur_src, saved);

    // Reset while a request is pending, then request src 3 on the auto-expiry tick.
    request((m_src + 1) % NS);
    repeat (2) step();
    auto_en = 1'b1;
    do_reset();
    n = 0;
    while (!(m_mode == MRun && m_dwell == DWELL - 1 && fpos == 0) && n < 100) begin
      step(); n++;
    end
    check("expiry_reached", n < 100, 1);
    check("expiry_src0", cur_src, 0);
    request(3);
    auto_en = 1'b0;
    pulses = 0;
    repeat (40) begin step(); if (switch_pulse) pulses++; end
    check("race_pulses", pulses, 1);
    check("race_cur_src", cur_src, 3);

    // Requested switch from source 0 to 2 issued mid-frame.
    do_reset();
    repeat (5) step();
    request(2);
    check("pend_ready", req_ready, 0);
    check("pend_cur_src", cur_src, 0);
    n = 0;
    while (!switch_pulse && n < 30) begin step(); n++; end
    check("req_pulse_seen", switch_pulse, 1);
    check("req_cur_src", cur_src, 2);
    repeat (40) step();

    // Border pixel handling.
    n = 0;
    while (m_mode != MRun && n < 100) begin step(); n++; end
    rnd_pix = 1'b0;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = DW'($urandom) | DW'(1);
    pixel_xpos = 10'd1;
    pixel_ypos = 10'd100;
    exp_pix = src_of(m_src);
`ifdef VGA_SCHED_BORDER_EN
    exp_pix = '1;
`endif
    step();
    check("border_x1", data_from_display, exp_pix);
    pixel_xpos = 10'd2;
    step();
    check("border_x2", data_from_display, src_of(m_src));
    rnd_pix = 1'b1;

    // fsync stuck high: the pending request waits indefinitely.
    saved = m_src;
    request((m_src + 1) % NS);
    stuck = 1'b1;
    repeat (50) step();
    check("stuck_ready", req_ready, 0);
    check("stuck_cur_src", cur_src, saved);
    stuck = 1'b0;

    // Random traffic.
    repeat (500) begin
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 7) == 0) request($urandom_range(0, 7));
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
